exc_vector_seq: RTL and testbench

- Exception-entry sequencer for the multicycle datapath; sits directly upstream of the memory-address select mux and drives its 3-bit IorD code during exception entry.
- On an exception request it runs the entry sequence: save EPC, select the cause-specific vector address code on IorD, wait for memory, capture the handler byte, and load the PC with it.
- The main control unit stalls while busy is high.

---
 rtl/exc_vector_seq.sv | 145 ++++++++++++++
 tb/tb_exc_vector_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/exc_vector_seq.sv
// rtl/exc_vector_seq.sv - exception-entry sequencer; optional sticky cause register under EXC_CAUSE_REG_EN
module exc_vector_seq #(
    parameter int unsigned MEM_LAT    = 1,
    parameter logic [31:0] EPC_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [2:0]  iord_out,
    output logic        iord_valid,
    output logic        mem_read,
    output logic        epc_write,
    output logic [31:0] epc_data,
    output logic        pc_write,
    output logic [31:0] pc_next,
    output logic        busy,
    output logic        done
`ifdef EXC_CAUSE_REG_EN
    ,
    input  logic        cause_clr,
    output logic [2:0]  cause_reg
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SAVE  = 2'd1,
        ST_FETCH = 2'd2,
        ST_JUMP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT       = MEM_LAT[2:0];
    localparam logic [2:0] CODE_OPC  = 3'b010;
    localparam logic [2:0] CODE_OVF  = 3'b011;
    localparam logic [2:0] CODE_DIV0 = 3'b100;

    state_t      state_q, state_d;
    logic [2:0]  cause_q, cause_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        req_any;

    assign req_any = exc_opcode | exc_overflow | exc_div0;

    // State and datapath registers; reset returns to IDLE with everything cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cause_q   <= 3'b000;
            cnt_q     <= 3'd0;
            epc_q     <= 32'd0;
            pc_next_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            epc_q     <= epc_d;
            pc_next_q <= pc_next_d;
        end
    end

    // Next-state and strobe decode; requests are only looked at in IDLE
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        cnt_d      = cnt_q;
        epc_d      = epc_q;
        pc_next_d  = pc_next_q;
        iord_out   = 3'b000;
        iord_valid = 1'b0;
        mem_read   = 1'b0;
        epc_write  = 1'b0;
        pc_write   = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    if (exc_opcode)        cause_d = CODE_OPC;
                    else if (exc_overflow) cause_d = CODE_OVF;
                    else                   cause_d = CODE_DIV0;
                    epc_d   = pc_in - EPC_OFFSET;
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                epc_write = 1'b1;
                cnt_d     = 3'd0;
                state_d   = ST_FETCH;
            end
            ST_FETCH: begin
                iord_valid = 1'b1;
                mem_read   = 1'b1;
                iord_out   = cause_q;
                if (cnt_q == LAT) begin
                    pc_next_d = {24'b0, mem_data_in[7:0]};
                    state_d   = ST_JUMP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_JUMP: begin
                pc_write = 1'b1;
                done     = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign epc_data = epc_q;
    assign pc_next  = pc_next_q;

`ifdef EXC_CAUSE_REG_EN
    logic [2:0] cause_reg_q, cause_reg_d;
    logic [2:0] cause_set;

    // One-hot sticky cause; a set on the same edge as a clear survives
    always_comb begin
        cause_set = 3'b000;
        if (state_q == ST_IDLE && req_any) begin
            if (exc_opcode)        cause_set = 3'b001;
            else if (exc_overflow) cause_set = 3'b010;
            else                   cause_set = 3'b100;
        end
        cause_reg_d = (cause_clr ? 3'b000 : cause_reg_q) | cause_set;
    end

    // Cause register storage
    always_ff @(posedge clk) begin
        if (reset) cause_reg_q <= 3'b000;
        else       cause_reg_q <= cause_reg_d;
    end

    assign cause_reg = cause_reg_q;
`endif

endmodule

// File: tb/tb_exc_vector_seq.sv
// tb/tb_exc_vector_seq.sv - directed self-checking bench for exc_vector_seq
module tb_exc_vector_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_opcode, exc_overflow, exc_div0;
    logic [31:0] pc_in, mem_data_in;
    logic [2:0]  iord_out;
    logic        iord_valid, mem_read, epc_write, pc_write, busy, done;
    logic [31:0] epc_data, pc_next;
`ifdef EXC_CAUSE_REG_EN
    logic        cause_clr;
    logic [2:0]  cause_reg;
    logic        cause_clr3;
    logic [2:0]  cause_reg3;
`endif

    logic        op3;
    logic [2:0]  iord_out3;
    logic        iord_valid3, mem_read3, epc_write3, pc_write3, busy3, done3;
    logic [31:0] epc_data3, pc_next3;

    int n_checks = 0;
    int n_pass   = 0;
    int pcw_count = 0;

    always #5 clk = ~clk;

    exc_vector_seq #(.MEM_LAT(1), .EPC_OFFSET(32'd4)) u_dut (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
        .pc_in(pc_in), .mem_data_in(mem_data_in),
        .iord_out(iord_out), .iord_valid(iord_valid), .mem_read(mem_read),
        .epc_write(epc_write), .epc_data(epc_data),
        .pc_write(pc_write), .pc_next(pc_next), .busy(busy), .done(done)
`ifdef EXC_CAUSE_REG_EN
        , .cause_clr(cause_clr), .cause_reg(cause_reg)
`endif
    );

    exc_vector_seq #(.MEM_LAT(3), .EPC_OFFSET(32'd4)) u_dut3 (
        .clk(clk), .reset(reset),
        .exc_opcode(op3), .exc_overflow(1'b0), .exc_div0(1'b0),
        .pc_in(pc_in), .mem_data_in(mem_data_in),
        .iord_out(iord_out3), .iord_valid(iord_valid3), .mem_read(mem_read3),
        .epc_write(epc_write3), .epc_data(epc_data3),
        .pc_write(pc_write3), .pc_next(pc_next3), .busy(busy3), .done(done3)
`ifdef EXC_CAUSE_REG_EN
        , .cause_clr(cause_clr3), .cause_reg(cause_reg3)
`endif
    );

    always @(posedge clk) if (pc_write) pcw_count <= pcw_count + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pcw_snap;
    int fetch_cycles;
    int jump_cycle;
    logic [7:0] busy_h, epcw_h, pcw_h;

    initial begin
        reset = 1'b1;
        exc_opcode = 0; exc_overflow = 0; exc_div0 = 0;
        pc_in = 32'h0; mem_data_in = 32'h0; op3 = 0;
`ifdef EXC_CAUSE_REG_EN
        cause_clr = 0; cause_clr3 = 0;
`endif
        tick(); tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_iord", {29'b0, iord_out}, 0);
        check("rst_epc", epc_data, 0);
        check("rst_pcnext", pc_next, 0);
        check("rst_pcw", {31'b0, pc_write}, 0);
        reset = 1'b0;
        tick();

        // Overflow sequence, with an opcode pulse during FETCH that must be ignored
        pcw_snap = pcw_count;
        pc_in = 32'h40; exc_overflow = 1;
        tick();                                   // cycle 1
        exc_overflow = 0;
        check("ovf_c1_epcw", {31'b0, epc_write}, 1);
        check("ovf_c1_epc", epc_data, 32'h3C);
        check("ovf_c1_busy", {31'b0, busy}, 1);
        check("ovf_c1_ivld", {31'b0, iord_valid}, 0);
        tick();                                   // cycle 2
        check("ovf_c2_iord", {29'b0, iord_out}, 3'b011);
        check("ovf_c2_ivld", {31'b0, iord_valid}, 1);
        check("ovf_c2_mrd", {31'b0, mem_read}, 1);
        check("ovf_c2_epcw", {31'b0, epc_write}, 0);
        exc_opcode = 1;
        tick();                                   // cycle 3
        exc_opcode = 0;
        mem_data_in = 32'hFFFF_FFA7;
        check("ovf_c3_iord", {29'b0, iord_out}, 3'b011);
        check("ovf_c3_mrd", {31'b0, mem_read}, 1);
        tick();                                   // cycle 4
        mem_data_in = 32'h0000_0055;
        check("ovf_c4_pcw", {31'b0, pc_write}, 1);
        check("ovf_c4_done", {31'b0, done}, 1);
        check("ovf_c4_pcnext", pc_next, 32'h0000_00A7);
        check("ovf_c4_busy", {31'b0, busy}, 1);
        check("ovf_c4_ivld", {31'b0, iord_valid}, 0);
        tick();                                   // cycle 5
        check("ovf_c5_busy", {31'b0, busy}, 0);
        check("ovf_c5_pcw", {31'b0, pc_write}, 0);
        check("ovf_hold_pcnext", pc_next, 32'h0000_00A7);
        check("ovf_hold_epc", epc_data, 32'h3C);
        tick(); tick();
        check("ovf_one_pcw", pcw_count - pcw_snap, 1);

`ifdef EXC_CAUSE_REG_EN
        check("cause_ovf", {29'b0, cause_reg}, 3'b010);
        cause_clr = 1;
        tick();
        cause_clr = 0;
        check("cause_clr", {29'b0, cause_reg}, 3'b000);
`endif

        // All three requests together: opcode has priority
        pc_in = 32'h100; exc_opcode = 1; exc_overflow = 1; exc_div0 = 1;
        tick();
        exc_opcode = 0; exc_overflow = 0; exc_div0 = 0;
        check("all_epc", epc_data, 32'hFC);
`ifdef EXC_CAUSE_REG_EN
        check("all_cause", {29'b0, cause_reg}, 3'b001);
`endif
        tick();
        check("all_iord", {29'b0, iord_out}, 3'b010);
        tick(); tick();
        check("all_pcw", {31'b0, pc_write}, 1);
        tick(); tick();

        // div0 with EPC wrapping below zero
        pc_in = 32'h2; exc_div0 = 1;
        tick();
        exc_div0 = 0;
        check("div0_epc", epc_data, 32'hFFFF_FFFE);
        tick();
        check("div0_iord", {29'b0, iord_out}, 3'b100);
        tick(); tick();
        check("div0_pcw", {31'b0, pc_write}, 1);
        tick(); tick();

        // Reset in the second FETCH cycle aborts the sequence
        pc_in = 32'h80; exc_overflow = 1;
        tick();                                   // SAVE
        exc_overflow = 0;
        tick();                                   // FETCH 1
        tick();                                   // FETCH 2
        pcw_snap = pcw_count;
        reset = 1;
        tick();
        reset = 0;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_ivld", {31'b0, iord_valid}, 0);
        check("abort_pcw", {31'b0, pc_write}, 0);
        check("abort_pcnext", pc_next, 0);
        check("abort_epc", epc_data, 0);
        for (int i = 0; i < 6; i++) tick();
        check("abort_no_pcw", pcw_count - pcw_snap, 0);

        // MEM_LAT=3 instance with opcode held: 4 FETCH cycles, then back-to-back restart
        op3 = 1;
        fetch_cycles = 0;
        jump_cycle = -1;
        busy_h = '0; epcw_h = '0; pcw_h = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            busy_h[c-1] = busy3;
            epcw_h[c-1] = epc_write3;
            pcw_h[c-1]  = pc_write3;
            if (mem_read3) fetch_cycles++;
            if (pc_write3 && jump_cycle < 0) jump_cycle = c;
        end
        op3 = 0;
        check("lat3_save", {31'b0, epcw_h[0]}, 1);
        check("lat3_fetch_len", fetch_cycles, 4);
        check("lat3_jump_cycle", jump_cycle, 6);
        check("lat3_idle_c7", {31'b0, busy_h[6]}, 0);
        check("lat3_restart_c8", {31'b0, epcw_h[7]}, 1);
        check("lat3_pcw_c7", {31'b0, pcw_h[6]}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
